// File: rtl/cmp_cmd_seq.sv
// Byte-framed command sequencer: collects a command and two 16-bit operands,
// issues one comparator operation, and returns the comparator result as a byte.
module cmp_cmd_seq #(
  parameter int IN_DATA_WIDTH  = 16,
  parameter int OUT_DATA_WIDTH = 3,
  parameter int WAIT_MAX       = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [7:0]                RX_DATA,
  input  logic                      RX_VALID,
  output logic                      RX_READY,
  output logic [IN_DATA_WIDTH-1:0]  CMP_A,
  output logic [IN_DATA_WIDTH-1:0]  CMP_B,
  output logic [1:0]                CMP_FUNC,
  output logic                      CMP_EN,
  input  logic [OUT_DATA_WIDTH-1:0] CMP_OUT,
  input  logic                      CMP_FLAG,
  output logic [7:0]                RES_DATA,
  output logic                      RES_VALID,
  input  logic                      RES_READY,
  output logic                      FRM_ERR,
  output logic                      BUSY
);

  localparam int CNT_W = $clog2(WAIT_MAX + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_A_LO, S_A_HI, S_B_LO, S_B_HI, S_ISSUE, S_WAIT, S_RESP
  } state_t;

  state_t                   state_q, state_d;
  logic [IN_DATA_WIDTH-1:0] a_reg, b_reg, b_full;
  logic [CNT_W-1:0]         wait_cnt;
  logic                     rx_fire, cmd_ok, timeout;

  function automatic logic [7:0] zext_res(input logic [OUT_DATA_WIDTH-1:0] v);
    logic [7:0] r;
    r = '0;
    r[OUT_DATA_WIDTH-1:0] = v;
    return r;
  endfunction

  assign RX_READY  = (state_q == S_IDLE) || (state_q == S_A_LO) || (state_q == S_A_HI) ||
                     (state_q == S_B_LO) || (state_q == S_B_HI);
  assign CMP_EN    = (state_q == S_ISSUE);
  assign RES_VALID = (state_q == S_RESP);
  assign BUSY      = (state_q != S_IDLE);

  assign rx_fire = RX_VALID && RX_READY;
  assign cmd_ok  = (RX_DATA[7:2] == 6'b101011);
  // The last WAIT cycle with no flag ends the frame without a result.
  assign timeout = (state_q == S_WAIT) && !CMP_FLAG && (wait_cnt == CNT_W'(WAIT_MAX - 1));

  always_comb begin
    b_full       = b_reg;
    b_full[15:8] = RX_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (rx_fire && cmd_ok) state_d = S_A_LO;
      S_A_LO:  if (rx_fire) state_d = S_A_HI;
      S_A_HI:  if (rx_fire) state_d = S_B_LO;
      S_B_LO:  if (rx_fire) state_d = S_B_HI;
      S_B_HI:  if (rx_fire) state_d = S_ISSUE;
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        if (CMP_FLAG)     state_d = S_RESP;
        else if (timeout) state_d = S_IDLE;
      end
      S_RESP:  if (RES_READY) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      a_reg    <= '0;
      b_reg    <= '0;
      CMP_A    <= '0;
      CMP_B    <= '0;
      CMP_FUNC <= '0;
      RES_DATA <= '0;
      FRM_ERR  <= 1'b0;
      wait_cnt <= '0;
    end else begin
      FRM_ERR <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (rx_fire) begin
            if (cmd_ok) CMP_FUNC <= RX_DATA[1:0];
            else        FRM_ERR  <= 1'b1;
          end
        end
        S_A_LO: if (rx_fire) a_reg[7:0]  <= RX_DATA;
        S_A_HI: if (rx_fire) a_reg[15:8] <= RX_DATA;
        S_B_LO: if (rx_fire) b_reg[7:0]  <= RX_DATA;
        S_B_HI: begin
          // Comparator operands change only here, on the way into ISSUE.
          if (rx_fire) begin
            b_reg[15:8] <= RX_DATA;
            CMP_A       <= a_reg;
            CMP_B       <= b_full;
          end
        end
        S_ISSUE: wait_cnt <= '0;
        S_WAIT: begin
          if (CMP_FLAG) begin
            RES_DATA <= zext_res(CMP_OUT);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
            if (timeout) FRM_ERR <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cmp_cmd_seq.sv
// Randomized self-checking bench for cmp_cmd_seq; the bench also plays the
// comparator, answering each CMP_EN after a chosen number of WAIT cycles.
module tb_cmp_cmd_seq;

  localparam int WAIT_MAX = 4;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic [7:0]  RX_DATA = '0;
  logic        RX_VALID = 1'b0;
  logic        RX_READY;
  logic [15:0] CMP_A, CMP_B;
  logic [1:0]  CMP_FUNC;
  logic        CMP_EN;
  logic [2:0]  CMP_OUT = '0;
  logic        CMP_FLAG = 1'b0;
  logic [7:0]  RES_DATA;
  logic        RES_VALID;
  logic        RES_READY = 1'b0;
  logic        FRM_ERR;
  logic        BUSY;

  int n_vec = 0;
  int n_err = 0;

  // Model of what the block has most recently latched
  logic [15:0] exp_a = '0, exp_b = '0;
  logic [1:0]  exp_func = '0;

  cmp_cmd_seq #(.IN_DATA_WIDTH(16), .OUT_DATA_WIDTH(3), .WAIT_MAX(WAIT_MAX)) dut (
    .CLK(CLK), .RST(RST), .RX_DATA(RX_DATA), .RX_VALID(RX_VALID), .RX_READY(RX_READY),
    .CMP_A(CMP_A), .CMP_B(CMP_B), .CMP_FUNC(CMP_FUNC), .CMP_EN(CMP_EN),
    .CMP_OUT(CMP_OUT), .CMP_FLAG(CMP_FLAG), .RES_DATA(RES_DATA), .RES_VALID(RES_VALID),
    .RES_READY(RES_READY), .FRM_ERR(FRM_ERR), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic noise();
    CMP_FLAG = 1'($urandom_range(0, 1));
    CMP_OUT  = 3'($urandom_range(0, 7));
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    for (int i = 0; i < gap; i++) begin
      RX_VALID = 1'b0;
      RX_DATA  = 8'($urandom);
      noise();
      step();
    end
    RX_VALID = 1'b1;
    RX_DATA  = b;
    noise();
    chk("rx_ready_before_byte", RX_READY, 1);
    step();
    RX_VALID = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, BUSY, 0);
    chk({tag, "_rx_ready"}, RX_READY, 1);
    chk({tag, "_res_valid"}, RES_VALID, 0);
    chk({tag, "_cmp_en"}, CMP_EN, 0);
  endtask

  // d = WAIT cycles before the comparator flag (d >= WAIT_MAX means it never answers),
  // r = cycles RES_READY stays low in RESP, pre = RES_READY already high beforehand.
  task automatic frame(input logic [7:0] cmd, input logic [15:0] a, input logic [15:0] b,
                       input int gap, input int d, input int r, input bit pre,
                       input logic [2:0] rsp);
    bit done;
    RES_READY = pre;
    send_byte(cmd, gap);
    exp_func = cmd[1:0];
    chk("func_latched", CMP_FUNC, exp_func);
    chk("busy_in_frame", BUSY, 1);
    send_byte(8'(a % 256), gap);
    send_byte(8'(a / 256), gap);
    send_byte(8'(b % 256), gap);
    chk("cmp_a_hold", CMP_A, exp_a);
    chk("cmp_b_hold", CMP_B, exp_b);
    send_byte(8'(b / 256), gap);
    exp_a = a;
    exp_b = b;
    chk("issue_cmp_en", CMP_EN, 1);
    chk("issue_cmp_a", CMP_A, exp_a);
    chk("issue_cmp_b", CMP_B, exp_b);
    chk("issue_cmp_func", CMP_FUNC, exp_func);
    chk("issue_rx_ready", RX_READY, 0);
    noise();
    done = 0;
    for (int p = 1; p <= WAIT_MAX + 3 && !done; p++) begin
      step();
      if (d >= WAIT_MAX && p == WAIT_MAX + 1) begin
        chk("timeout_frm_err", FRM_ERR, 1);
        chk("timeout_busy", BUSY, 0);
        chk("timeout_res_valid", RES_VALID, 0);
        done = 1;
      end else if (d < WAIT_MAX && p == d + 2) begin
        chk("resp_valid", RES_VALID, 1);
        chk("resp_data", RES_DATA, {5'b0, rsp});
        done = 1;
      end else begin
        chk("wait_res_valid", RES_VALID, 0);
        chk("wait_frm_err", FRM_ERR, 0);
        chk("wait_cmp_en", CMP_EN, 0);
        chk("wait_rx_ready", RX_READY, 0);
        CMP_FLAG = (p - 1 == d);
        CMP_OUT  = (p - 1 == d) ? rsp : 3'($urandom_range(0, 7));
      end
    end
    if (!done) chk("wait_bound_expired", 0, 1);
    noise();
    if (d >= WAIT_MAX) begin
      step();
      chk("timeout_frm_err_pulse", FRM_ERR, 0);
      check_idle_outputs("after_timeout");
    end else begin
      if (!pre) begin
        for (int i = 0; i < r; i++) begin
          step();
          noise();
          chk("resp_hold_valid", RES_VALID, 1);
          chk("resp_hold_data", RES_DATA, {5'b0, rsp});
        end
        RES_READY = 1'b1;
      end
      step();
      check_idle_outputs("after_resp");
      chk("after_resp_frm_err", FRM_ERR, 0);
    end
    RES_READY = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_cmp_a"}, CMP_A, 0);
    chk({tag, "_cmp_b"}, CMP_B, 0);
    chk({tag, "_cmp_func"}, CMP_FUNC, 0);
    chk({tag, "_res_data"}, RES_DATA, 0);
    chk({tag, "_frm_err"}, FRM_ERR, 0);
    check_idle_outputs(tag);
  endtask

  initial begin
    logic [7:0]  cmd;
    logic [15:0] ra, rb;
    int          rd;

    step();
    step();
    check_reset_state("reset");
    RST = 1'b0;

    // Equal operands, function 01, immediate comparator response
    frame(8'hAD, 16'h1234, 16'h1234, 0, 0, 0, 0, 3'd1);
    // Result held while downstream stalls for 3 cycles
    frame(8'hAE, 16'h8000, 16'h7FFF, 0, 0, 3, 0, 3'd2);

    // Invalid command byte is dropped with a single error pulse
    send_byte(8'h55, 0);
    chk("bad_cmd_frm_err", FRM_ERR, 1);
    chk("bad_cmd_busy", BUSY, 0);
    chk("bad_cmd_func_kept", CMP_FUNC, exp_func);
    step();
    chk("bad_cmd_frm_err_pulse", FRM_ERR, 0);
    frame(8'hAF, 16'hBEEF, 16'h0102, 0, 0, 1, 0, 3'd5);

    // Comparator never answers
    frame(8'hAC, 16'h00FF, 16'hFF00, 0, WAIT_MAX, 0, 0, 3'd0);

    // Reset after the A high byte abandons the frame
    send_byte(8'hAD, 0);
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    exp_a = '0;
    exp_b = '0;
    exp_func = '0;
    check_reset_state("mid_frame_reset");
    frame(8'hAD, 16'h1234, 16'h1234, 0, 0, 0, 0, 3'd1);

    // Gapped byte stream, one valid cycle in three
    frame(8'hAD, 16'h1234, 16'h1234, 2, 0, 0, 0, 3'd1);
    // RES_READY already high: single-cycle RESP
    frame(8'hAE, 16'hA5A5, 16'h5A5A, 0, 0, 0, 1, 3'd6);

    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        cmd = 8'($urandom);
        if (cmd[7:2] == 6'b101011) cmd[7] = 1'b0;
        send_byte(cmd, $urandom_range(0, 1));
        chk("rand_bad_frm_err", FRM_ERR, 1);
        step();
        chk("rand_bad_frm_err_pulse", FRM_ERR, 0);
      end
      cmd = 8'hAC + 8'($urandom_range(0, 3));
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rd  = ($urandom_range(0, 5) == 0) ? WAIT_MAX : $urandom_range(0, WAIT_MAX - 1);
      frame(cmd, ra, rb, $urandom_range(0, 2), rd, $urandom_range(0, 3),
            1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
